// File: rtl/serial_full_subtractor_pkg.sv
// serial_full_subtractor_pkg: shared state encoding and counter-width helper for the bit-serial subtractor
//   state_t      IDLE / RUN / DONE encoding of the control FSM
//   count_width  bits needed for a counter that walks 0..w-1
package serial_full_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int count_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit subtractor cell (a - b - bin)
//   a, b   operand bits
//   bin    borrow in
//   d      difference bit
//   bout   borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// serial_full_subtractor: bit-serial a - b, LSB first, with start/busy/done handshake
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            request, sampled only while idle
//   a, b             minuend / subtrahend, captured on the accepting edge
//   busy             high while the operation is running or completing
//   done             one-cycle pulse; diff/borrow_out/overflow valid from here on
//   diff             a - b mod 2^WIDTH
//   borrow_out       1 when a < b (unsigned)
//   overflow         signed overflow of a - b
module serial_full_subtractor
    import serial_full_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = count_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    count;
    logic             borrow, a_msb, b_msb, d, bout;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            count      <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    borrow <= 1'b0;
                    count  <= '0;
                    a_msb  <= a[WIDTH-1];
                    b_msb  <= b[WIDTH-1];
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    // result bits enter at the top so the LSB ends up at bit 0 after WIDTH shifts
                    r_sh   <= {d, r_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= bout;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= DONE;
                end
                DONE: begin
                    done       <= 1'b1;
                    diff       <= r_sh;
                    borrow_out <= borrow;
                    // signed overflow only possible when operand signs differ
                    overflow   <= (a_msb != b_msb) && (r_sh[WIDTH-1] != a_msb);
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
